// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset controller and its synchronizers.
package pll_reset_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } pll_rst_state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_PLL_RST_CYCLES     = 16;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGGER_CYCLES     = 8;
  localparam int DEF_RELOCK_TIMEOUT     = 65536;
  localparam int RELOCK_CNT_W           = 8;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset to 0.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// Sequences PLL reset, lock qualification and staggered per-domain reset release;
// any loss of lock or lock timeout re-asserts all downstream resets and retries the PLL.
module pll_reset_ctrl
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGGER_CYCLES     = DEF_STAGGER_CYCLES,
  parameter int RELOCK_TIMEOUT     = DEF_RELOCK_TIMEOUT
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    locked,
  output logic                    pll_rst,
  output logic                    rst_out_0,
  output logic                    rst_out_1,
  output logic                    ready,
  output logic [RELOCK_CNT_W-1:0] relock_count
);

  localparam int CNT_MAX = max4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, STAGGER_CYCLES, RELOCK_TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]        PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]        STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        STAG_LAST   = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]        TMO_LAST    = CNT_W'(RELOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1);
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_ONE  = RELOCK_CNT_W'(1);
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_SAT  = '1;

  pll_rst_state_t          state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pll_rst_q;
  logic                    rst_out_0_q;
  logic                    rst_out_1_q;
  logic                    ready_q;
  logic [RELOCK_CNT_W-1:0] relock_q;
  logic                    locked_s;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_i (refclk),
    .rst_i (rst),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= PLL_RESET;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_out_0_q <= 1'b1;
      rst_out_1_q <= 1'b1;
      ready_q     <= 1'b0;
      relock_q    <= '0;
    end else begin
      case (state_q)
        PLL_RESET: begin
          if (cnt_q == PLL_LAST) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (relock_q != RELOCK_SAT) relock_q <= relock_q + RELOCK_ONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        // A dropout here is treated as a glitch: restart the window, no retry.
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q     <= RELEASE;
            cnt_q       <= '0;
            rst_out_1_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RELEASE, RUN: begin
          if (!locked_s) begin
            state_q     <= PLL_RESET;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            rst_out_0_q <= 1'b1;
            rst_out_1_q <= 1'b1;
            ready_q     <= 1'b0;
            if (relock_q != RELOCK_SAT) relock_q <= relock_q + RELOCK_ONE;
          end else if (state_q == RELEASE) begin
            if (cnt_q == STAG_LAST) begin
              state_q     <= RUN;
              cnt_q       <= '0;
              rst_out_0_q <= 1'b0;
              ready_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= PLL_RESET;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pll_rst      = pll_rst_q;
  assign rst_out_0    = rst_out_0_q;
  assign rst_out_1    = rst_out_1_q;
  assign ready        = ready_q;
  assign relock_count = relock_q;

endmodule
